// File: rtl/fft_frame_ctrl.sv
// Frame sequencer that feeds 512-point frames into the bit-reversal/FFT input stage.
// It forwards 32 blocks as one burst, inserts the terminating gap, then waits for the output burst.
module fft_frame_ctrl #(
    parameter int WIDTH_IN      = 13,
    parameter int ARRAY_IN      = 16,
    parameter int MAX_POINT     = 512,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic signed [ARRAY_IN-1:0][WIDTH_IN-1:0] in_i,
    input  logic signed [ARRAY_IN-1:0][WIDTH_IN-1:0] in_q,
    output logic                                     fft_din_valid,
    output logic signed [ARRAY_IN-1:0][WIDTH_IN-1:0] fft_din_i,
    output logic signed [ARRAY_IN-1:0][WIDTH_IN-1:0] fft_din_q,
    input  logic                                     fft_do_en,
    output logic                                     busy,
    output logic                                     frame_done,
    output logic                                     err_abort,
    output logic                                     err_timeout,
    output logic [5:0]                               drain_beats,
    output logic [15:0]                              frame_cnt,
    output logic [15:0]                              drop_cnt
);
    localparam int NBLK  = MAX_POINT / ARRAY_IN;
    localparam int BLK_W = $clog2(NBLK);
    localparam int TO_W  = $clog2(DRAIN_TIMEOUT);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(NBLK - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, GAP, DRAIN} state_t;

    state_t           state;
    logic [BLK_W-1:0] blk_cnt;
    logic [5:0]       beat_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             do_prev;
    logic             accept;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // in_ready is held low during reset even though the state already reads IDLE.
    assign in_ready = !rst && ((state == IDLE) || (state == LOAD));
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fft_din_valid <= 1'b0;
            fft_din_i     <= '0;
            fft_din_q     <= '0;
        end else begin
            fft_din_valid <= accept;
            if (accept) begin
                fft_din_i <= in_i;
                fft_din_q <= in_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            blk_cnt     <= '0;
            beat_cnt    <= '0;
            to_cnt      <= '0;
            do_prev     <= 1'b0;
            frame_done  <= 1'b0;
            err_abort   <= 1'b0;
            err_timeout <= 1'b0;
            drain_beats <= '0;
            frame_cnt   <= '0;
            drop_cnt    <= '0;
        end else begin
            frame_done  <= 1'b0;
            err_abort   <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        blk_cnt <= BLK_W'(1);
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        blk_cnt <= blk_cnt + 1'b1;
                        if (blk_cnt == BLK_LAST) state <= GAP;
                    end else begin
                        // Stall mid-load: the downstream sees valid fall early and rewinds itself.
                        err_abort <= 1'b1;
                        drop_cnt  <= sat_inc(drop_cnt);
                        blk_cnt   <= '0;
                        state     <= IDLE;
                    end
                end
                GAP: begin
                    beat_cnt <= '0;
                    to_cnt   <= '0;
                    do_prev  <= 1'b0;
                    state    <= DRAIN;
                end
                DRAIN: begin
                    do_prev <= fft_do_en;
                    if (fft_do_en) begin
                        if (beat_cnt != 6'h3F) beat_cnt <= beat_cnt + 6'd1;
                        to_cnt <= '0;
                    end else if (do_prev && (beat_cnt != 6'd0)) begin
                        drain_beats <= beat_cnt;
                        frame_done  <= 1'b1;
                        frame_cnt   <= sat_inc(frame_cnt);
                        state       <= IDLE;
                    end else if (beat_cnt == 6'd0) begin
                        if (to_cnt == TO_LAST) begin
                            err_timeout <= 1'b1;
                            drop_cnt    <= sat_inc(drop_cnt);
                            state       <= IDLE;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl: stimulus pushes expected blocks and pulse events,
// a negedge monitor pops and compares whenever the DUT presents a valid block or a pulse.
module tb_fft_frame_ctrl;
    localparam int W    = 13;
    localparam int A    = 16;
    localparam int NBLK = 32;
    localparam int TMO  = 64;

    typedef logic signed [A-1:0][W-1:0] lanes_t;
    typedef struct {lanes_t i; lanes_t q;} blk_t;
    typedef struct {int kind; int cyc; int beats; int fcnt; int dcnt;} evt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    lanes_t      in_i;
    lanes_t      in_q;
    logic        fft_din_valid;
    lanes_t      fft_din_i;
    lanes_t      fft_din_q;
    logic        fft_do_en;
    logic        busy;
    logic        frame_done;
    logic        err_abort;
    logic        err_timeout;
    logic [5:0]  drain_beats;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    blk_t data_q[$];
    evt_t evt_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   m_frame = 0;
    int   m_drop  = 0;
    int   m_beats = 0;

    fft_frame_ctrl #(.WIDTH_IN(W), .ARRAY_IN(A), .MAX_POINT(512), .DRAIN_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_i(in_i), .in_q(in_q), .fft_din_valid(fft_din_valid),
        .fft_din_i(fft_din_i), .fft_din_q(fft_din_q), .fft_do_en(fft_do_en),
        .busy(busy), .frame_done(frame_done), .err_abort(err_abort),
        .err_timeout(err_timeout), .drain_beats(drain_beats),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    // Monitor: pops one expected block per valid beat and one expected event per pulse.
    always @(negedge clk) begin : monitor
        blk_t b;
        evt_t e;
        if (!rst) begin
            if (fft_din_valid) begin
                if (data_q.size() == 0) checkOutput("spurious_valid", 1, 0);
                else begin
                    b = data_q.pop_front();
                    checkOutput("din_i", fft_din_i, b.i);
                    checkOutput("din_q", fft_din_q, b.q);
                end
            end
            if (frame_done || err_abort || err_timeout) begin
                if (evt_q.size() == 0) checkOutput("spurious_pulse", {frame_done, err_abort, err_timeout}, 0);
                else begin
                    e = evt_q.pop_front();
                    checkOutput("pulse_kind", {frame_done, err_abort, err_timeout}, e.kind);
                    checkOutput("pulse_cycle", cyc, e.cyc);
                    checkOutput("drain_beats", drain_beats, e.beats);
                    checkOutput("frame_cnt", frame_cnt, e.fcnt);
                    checkOutput("drop_cnt", drop_cnt, e.dcnt);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_evt(input int kind);
        evt_t e;
        e.kind = kind; e.cyc = cyc; e.beats = m_beats; e.fcnt = m_frame; e.dcnt = m_drop;
        evt_q.push_back(e);
    endtask

    function automatic lanes_t rand_lanes();
        lanes_t x;
        for (int l = 0; l < A; l++) x[l] = W'($urandom);
        return x;
    endfunction

    task automatic drive_block(input int b, input bit idx_data);
        blk_t x;
        if (idx_data) begin
            for (int l = 0; l < A; l++) begin x.i[l] = W'(b); x.q[l] = W'(b); end
        end else begin
            x.i = rand_lanes(); x.q = rand_lanes();
        end
        checkOutput("ready_load", in_ready, 1);
        in_valid  = 1'b1;
        in_i      = x.i;
        in_q      = x.q;
        fft_do_en = 1'($urandom);
        data_q.push_back(x);
        step();
    endtask

    // Full frame; beats == 0 withholds do_en so the drain times out.
    task automatic applyStimulus(input int beats, input int delay, input bit hold_valid, input bit idx_data);
        for (int b = 0; b < NBLK; b++) drive_block(b, idx_data);
        checkOutput("ready_gap", in_ready, 0);
        checkOutput("busy_gap", busy, 1);
        in_valid = hold_valid; in_i = rand_lanes(); in_q = rand_lanes(); fft_do_en = 1'b1;
        step();
        if (beats == 0) begin
            for (int d = 0; d < TMO; d++) begin
                checkOutput("ready_drain", in_ready, 0);
                in_valid = hold_valid; in_i = rand_lanes(); fft_do_en = 1'b0;
                step();
            end
            m_drop = sat(m_drop);
            push_evt(1);
        end else begin
            for (int d = 0; d < delay + beats + 1; d++) begin
                checkOutput("ready_drain", in_ready, 0);
                in_valid = hold_valid; in_i = rand_lanes();
                fft_do_en = (d >= delay) && (d < delay + beats);
                step();
            end
            m_frame = sat(m_frame);
            m_beats = (beats > 63) ? 63 : beats;
            push_evt(4);
        end
        checkOutput("ready_after", in_ready, 1);
        checkOutput("busy_after", busy, 0);
        in_valid = 1'b0; fft_do_en = 1'b0;
    endtask

    task automatic abort_frame(input int n);
        for (int b = 0; b < n; b++) drive_block(b, 1'b0);
        checkOutput("ready_stall", in_ready, 1);
        in_valid = 1'b0; fft_do_en = 1'b0;
        step();
        m_drop = sat(m_drop);
        push_evt(2);
        checkOutput("ready_abort", in_ready, 1);
        checkOutput("busy_abort", busy, 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b0; fft_do_en = 1'($urandom);
            step();
        end
        fft_do_en = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        checkOutput({tag, "_ready"}, in_ready, 0);
        checkOutput({tag, "_valid"}, fft_din_valid, 0);
        checkOutput({tag, "_din"}, {fft_din_i, fft_din_q}, 0);
        checkOutput({tag, "_flags"}, {busy, frame_done, err_abort, err_timeout}, 0);
        checkOutput({tag, "_cnts"}, {drain_beats, frame_cnt, drop_cnt}, 0);
    endtask

    task automatic reset_mid_load();
        for (int b = 0; b < 20; b++) drive_block(b, 1'b0);
        in_valid = 1'b1; in_i = rand_lanes(); in_q = rand_lanes();
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_zero("rst_async");
        data_q.delete();
        m_frame = 0; m_drop = 0; m_beats = 0;
        in_valid = 1'b0;
        step();
        check_zero("rst_hold");
        rst = 1'b0;
        #1 checkOutput("ready_release", in_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; fft_do_en = 1'b0; in_i = '0; in_q = '0;
        #1 check_zero("reset");
        step(); step();
        rst = 1'b0;
        #1 checkOutput("ready_idle", in_ready, 1);
        step();

        applyStimulus(31, 0, 1'b0, 1'b1);
        idle_cycles(2);
        abort_frame(11);
        applyStimulus(10, 3, 1'b0, 1'b0);
        idle_cycles(1);
        applyStimulus(0, 0, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) applyStimulus(5 + f, f, 1'b1, 1'b0);
        reset_mid_load();
        step();
        applyStimulus(20, 2, 1'b0, 1'b0);
        checkOutput("frame_after_reset", frame_cnt, 1);

        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(0, 3))
                0:       abort_frame($urandom_range(1, NBLK - 1));
                1:       applyStimulus(0, 0, 1'($urandom), 1'b0);
                default: applyStimulus($urandom_range(1, 70), $urandom_range(0, 40), 1'($urandom), 1'b0);
            endcase
            idle_cycles($urandom_range(0, 3));
        end

        force dut.frame_cnt = 16'hFFFE;
        step();
        release dut.frame_cnt;
        m_frame = 16'hFFFE;
        for (int f = 0; f < 3; f++) applyStimulus(4, 1, 1'b1, 1'b0);
        idle_cycles(2);
        checkOutput("frame_cnt_sat", frame_cnt, 16'hFFFF);
        checkOutput("final_drop_cnt", drop_cnt, m_drop);
        checkOutput("data_q_empty", data_q.size(), 0);
        checkOutput("evt_q_empty", evt_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
